axi_lite_vram_slave: RTL
========================

Name: axi_lite_vram_slave

Overview:
Synthesizable AXI4-Lite responder that owns the text-mode VRAM (600 words) and the control register (word 600) for the HDMI text controller. It serves CPU reads and writes with full byte-strobe support. A second, read-only port feeds the glyph/draw pipeline on the same clock. It is the bus-side counterpart to the bench's AXI write/read initiator tasks.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_AXI_ADDR_WIDTH, 16, byte address width. Word index is addr[C_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
VRAM_WORDS, 600, number of VRAM words.

Ports:
axi_aclk  in  1  single clock for the bus and video read port.
axi_areset  in  1  synchronous, active-high reset.
axi_awaddr  in  C_AXI_ADDR_WIDTH  write byte address.
axi_awprot  in  3  ignored.
axi_awvalid / axi_awready  in / out  1  AW handshake.
axi_wdata  in  32  write data.
axi_wstrb  in  4  byte enables.
axi_wvalid / axi_wready  in / out  1  W handshake.
axi_bresp  out  2  write response.
axi_bvalid / axi_bready  out / in  1  B handshake.
axi_araddr  in  C_AXI_ADDR_WIDTH  read byte address.
axi_arprot  in  3  ignored.
axi_arvalid / axi_arready  in / out  1  AR handshake.
axi_rdata  out  32  read data.
axi_rresp  out  2  read response.
axi_rvalid / axi_rready  out / in  1  R handshake.
vid_addr  in  10  VRAM word index requested by the draw logic.
vid_data  out  32  registered VRAM word.
ctrl_reg  out  32  live control-register value (colour fields).

Behaviour:
- Reset (sync, active-high): awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rresp=0, rdata=0, vid_data=0, ctrl_reg=0.
  - Write FSM goes to W_IDLE; read FSM goes to R_IDLE.
  - VRAM contents are preserved across reset and undefined at power-up.
  - Reset mid-transaction drops every in-flight handshake with no response and no commit.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
  - W_IDLE: awready=1, wready=1. Both handshakes in the same cycle -> W_COMMIT. AW only -> W_HAVE_ADDR (awready=0). W only -> W_HAVE_DATA (wready=0).
  - W_HAVE_ADDR: wready=1; on W handshake -> W_COMMIT. W_HAVE_DATA: awready=1; on AW handshake -> W_COMMIT. Address and data/strb are latched at their handshake.
  - W_COMMIT (one cycle, both ready signals 0): byte-masked write of the latched word, then -> W_RESP.
  - W_RESP: bvalid=1 held until bready; on the B handshake -> W_IDLE.
  - Latency: final handshake at edge N -> memory updated at edge N+1 -> bvalid high from edge N+1 to N+2.
  - Index < 600 writes VRAM; index 600 writes ctrl_reg; both with bresp=OKAY.
  - Index > 600: no write, bresp=SLVERR.
  - Strobe bit k writes bits [8k+7:8k] only. wstrb=0 is a legal no-op that returns OKAY.
- Read FSM states: R_IDLE, R_FETCH, R_DATA.
  - R_IDLE: arready=1; on AR handshake latch the index -> R_FETCH (arready=0).
  - R_FETCH: one cycle for the BRAM read, then -> R_DATA.
  - R_DATA: rvalid=1, rdata and rresp held stable until rready, then -> R_IDLE.
  - Latency: AR at edge N -> rvalid from edge N+2.
  - Index 600 returns ctrl_reg. Index > 600 returns rdata=0 with rresp=SLVERR.
- Read and write FSMs run concurrently. If a read fetches the same word that W_COMMIT writes in the same cycle, the read returns the old value (read-first).
- Video port: vid_data = VRAM[vid_addr] registered, 1-cycle latency, independent of AXI traffic. vid_addr >= 600 returns 0.
- ctrl_reg updates on the edge ending W_COMMIT.

Decomposition:
- Package axi_lite_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, VRAM_WORDS=600, CTRL_INDEX=600, and enums wr_state_t and rd_state_t.
- Sub-module vram_bram_dp: true dual-port 600x32 RAM with 4-bit byte-write-enable and read-first behaviour.
  - Port A: AXI write and read, with the read/write muxed per cycle.
  - Port B: video read only.
  - If the AXI read and write collide on a cycle, the write owns port A and the read is delayed one cycle.
  - That read delay is the only permitted stretch of the R_FETCH latency.

Test Plan:
- AW and W asserted together at addr 0x0010, data 0xDEADBEEF, strb F -> bvalid 2 edges after assertion with bresp=00; a read of 0x0010 returns 0xDEADBEEF with rresp=00.
- W presented 3 cycles before AW (addr 0x0008, data 0x11223344), then AW 3 cycles after W -> one commit only, bresp=OKAY, and readback is 0x11223344.
- Word 5 preset to 0xAABBCCDD, then write 0x00000077 with strb 4'b0001 -> readback 0xAABBCC77. With strb 4'b1100 and data 0x55660000 -> 0x5566CC77.
- Write 0x001F6000 to byte addr 2400 -> ctrl_reg is 0x001F6000 after the commit edge. Write to byte addr 2404 -> bresp=SLVERR and no state change; a read of 2404 gives rdata=0 with rresp=SLVERR.
- bready held low 10 cycles -> bvalid and bresp stay stable, and awready/wready stay 0 throughout. Same check for rready held low: rdata stable and arready=0.
- Fill all 600 words with data=index, sweeping vid_addr 0..599 while AXI writes continue -> vid_data = index one cycle later.
  - Assert axi_areset during W_HAVE_ADDR -> next edge all valids and readies are 0, and the target word is unchanged.

Source files
------------

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared constants and state encodings for the VRAM AXI-Lite
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int VRAM_WORDS = 600;
    localparam int CTRL_INDEX = 600;

    typedef enum logic [2:0] {
        W_IDLE      = 3'd0,
        W_HAVE_ADDR = 3'd1,
        W_HAVE_DATA = 3'd2,
        W_COMMIT    = 3'd3,
        W_RESP      = 3'd4
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_bram_dp.sv
`default_nettype none
// ============================================================================
// Module      : vram_bram_dp
// Description : Dual-port 32-bit RAM, byte-write port A (read-first), read-only
//               port B with zero for out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_bram_dp
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = VRAM_WORDS,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_a_en,
    input  logic [3:0]    i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_wdata,
    output logic [31:0]   o_a_rdata,
    input  logic [AW-1:0] i_b_addr,
    output logic [31:0]   o_b_rdata
);

    localparam logic [AW-1:0] c_depth = AW'(DEPTH);

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;

    // Read-first: the output register takes the word before any byte update.
    always_ff @(posedge clk) begin
        if (i_a_en) begin
            r_a_rdata <= r_mem[i_a_addr];
            for (int k = 0; k < 4; k++) begin
                if (i_a_we[k]) begin
                    r_mem[i_a_addr][8*k +: 8] <= i_a_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_rdata <= '0;
        end else if (i_b_addr < c_depth) begin
            r_b_rdata <= r_mem[i_b_addr];
        end else begin
            r_b_rdata <= '0;
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_lite_vram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_vram_slave
// Description : AXI4-Lite responder owning text-mode VRAM plus the control
//               register, with a registered read port for the draw pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_vram_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int VRAM_WORDS       = 600
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    input  logic [9:0]                    vid_addr,
    output logic [31:0]                   vid_data,
    output logic [31:0]                   ctrl_reg
);
    import axi_lite_pkg::*;

    localparam int                  c_idx_w      = C_AXI_ADDR_WIDTH - 2;
    localparam int                  c_ram_aw     = $clog2(VRAM_WORDS);
    localparam logic [c_idx_w-1:0]  c_vram_words = c_idx_w'(VRAM_WORDS);
    localparam logic [c_idx_w-1:0]  c_ctrl_index = c_idx_w'(CTRL_INDEX);

    wr_state_t            r_wr_state;
    rd_state_t            r_rd_state;
    logic                 r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]           r_bresp, r_rresp;
    logic [31:0]          r_rdata, r_ctrl_reg, r_ctrl_snap, r_wr_data;
    logic [3:0]           r_wr_strb;
    logic [c_idx_w-1:0]   r_wr_idx, r_rd_idx;

    logic                 w_aw_hs, w_w_hs, w_ar_hs;
    logic                 w_commit, w_commit_mem, w_rd_in_vram, w_rd_grant, w_a_en;
    logic [c_ram_aw-1:0]  w_a_addr;
    logic [3:0]           w_a_we;
    logic [31:0]          w_a_rdata;
    logic                 w_unused;

    assign w_aw_hs = axi_awvalid & r_awready;
    assign w_w_hs  = axi_wvalid  & r_wready;
    assign w_ar_hs = axi_arvalid & r_arready;

    assign w_commit     = (r_wr_state == W_COMMIT) && !axi_areset;
    assign w_commit_mem = w_commit && (r_wr_idx < c_vram_words);
    assign w_rd_in_vram = r_rd_idx < c_vram_words;

    // A write owns port A; a read of the same word shares the cycle and sees
    // the old value thanks to the read-first RAM, any other read waits.
    assign w_rd_grant = (r_rd_state == R_FETCH) &&
                        (!w_commit_mem || !w_rd_in_vram || (r_rd_idx == r_wr_idx));
    assign w_a_en     = w_commit_mem || (w_rd_grant && w_rd_in_vram);
    assign w_a_addr   = w_commit_mem ? r_wr_idx[c_ram_aw-1:0] : r_rd_idx[c_ram_aw-1:0];
    assign w_a_we     = w_commit_mem ? r_wr_strb : 4'b0000;

    assign w_unused = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    vram_bram_dp #(
        .DEPTH (VRAM_WORDS),
        .AW    (c_ram_aw)
    ) u_vram (
        .clk       (axi_aclk),
        .rst       (axi_areset),
        .i_a_en    (w_a_en),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (r_wr_data),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (vid_addr),
        .o_b_rdata (vid_data)
    );

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_ctrl_reg <= '0;
            r_wr_idx   <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) r_wr_idx <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
                    if (w_w_hs) begin
                        r_wr_data <= axi_wdata;
                        r_wr_strb <= axi_wstrb;
                    end
                    if (w_aw_hs && w_w_hs) begin
                        r_wr_state <= W_COMMIT;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_wr_state <= W_HAVE_ADDR;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wr_state <= W_HAVE_DATA;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b0;
                    end else begin
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                W_HAVE_ADDR: begin
                    if (w_w_hs) begin
                        r_wr_data  <= axi_wdata;
                        r_wr_strb  <= axi_wstrb;
                        r_wready   <= 1'b0;
                        r_wr_state <= W_COMMIT;
                    end
                end
                W_HAVE_DATA: begin
                    if (w_aw_hs) begin
                        r_wr_idx   <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
                        r_awready  <= 1'b0;
                        r_wr_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    if (r_wr_idx == c_ctrl_index) begin
                        for (int k = 0; k < 4; k++) begin
                            if (r_wr_strb[k]) r_ctrl_reg[8*k +: 8] <= r_wr_data[8*k +: 8];
                        end
                    end
                    r_bresp    <= (r_wr_idx <= c_ctrl_index) ? RESP_OKAY : RESP_SLVERR;
                    r_bvalid   <= 1'b1;
                    r_wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // rvalid rises one cycle after the fetch so the RAM output has settled.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_rd_state  <= R_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_rd_idx    <= '0;
            r_ctrl_snap <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_idx   <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
                        r_arready  <= 1'b0;
                        r_rd_state <= R_FETCH;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                R_FETCH: begin
                    if (w_rd_grant) begin
                        r_ctrl_snap <= r_ctrl_reg;
                        r_rd_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (!r_rvalid) begin
                        r_rvalid <= 1'b1;
                        if (w_rd_in_vram) begin
                            r_rdata <= w_a_rdata;
                            r_rresp <= RESP_OKAY;
                        end else if (r_rd_idx == c_ctrl_index) begin
                            r_rdata <= r_ctrl_snap;
                            r_rresp <= RESP_OKAY;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= RESP_SLVERR;
                        end
                    end else if (axi_rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rresp   = r_rresp;
    assign axi_rdata   = r_rdata;
    assign ctrl_reg    = r_ctrl_reg;

endmodule
`default_nettype wire
